// File: rtl/dmi_port_arbiter.sv
// dmi_port_arbiter: grants one of two DMI requesters access to the core register port.
// Define DMI_ARB_ROUND_ROBIN_EN for round-robin arbitration; fixed priority to requester 0 otherwise.
module dmi_port_arbiter #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 32
) (
  input  logic              core_clk,
  input  logic              core_rst_n,
  input  logic              req0_valid,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_ack,
  output logic [DATA_W-1:0] req0_rdata,
  input  logic              req1_valid,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_ack,
  output logic [DATA_W-1:0] req1_rdata,
  output logic              reg_en,
  output logic              reg_wr_en,
  output logic [ADDR_W-1:0] reg_wr_addr,
  output logic [DATA_W-1:0] reg_wr_data,
  input  logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              grant_id
);
  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
  state_t state, state_nxt;
  logic start, win, we_q;
  logic [DATA_W-1:0] rdata0_q, rdata1_q;
  assign start = (state == IDLE) && (req0_valid || req1_valid);
`ifdef DMI_ARB_ROUND_ROBIN_EN
  logic last_q;
  always_ff @(posedge core_clk)
    if (!core_rst_n) last_q <= 1'b1;
    else if (start) last_q <= win;
  assign win = (req0_valid && req1_valid) ? ~last_q : ~req0_valid;
`else
  assign win = ~req0_valid;
`endif
  always_ff @(posedge core_clk)
    if (!core_rst_n) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = start ? ISSUE : (state == ISSUE) ? RESP : IDLE;
    busy = state != IDLE;
    reg_en = state == ISSUE;
    reg_wr_en = reg_en && we_q;
    req0_ack = (state == RESP) && !grant_id;
    req1_ack = (state == RESP) && grant_id;
    req0_rdata = (req0_ack && !we_q) ? rd_data : rdata0_q;
    req1_rdata = (req1_ack && !we_q) ? rd_data : rdata1_q;
  end
  // Request fields are captured only at grant so later input changes cannot reach the core.
  always_ff @(posedge core_clk)
    if (!core_rst_n) begin
      grant_id <= 1'b0;
      we_q <= 1'b0;
      reg_wr_addr <= '0;
      reg_wr_data <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      if (start) begin
        grant_id <= win;
        we_q <= win ? req1_we : req0_we;
        reg_wr_addr <= win ? req1_addr : req0_addr;
        reg_wr_data <= win ? req1_wdata : req0_wdata;
      end
      if (state == RESP && !we_q) begin
        if (grant_id) rdata1_q <= rd_data;
        else rdata0_q <= rd_data;
      end
    end
endmodule

// File: tb/tb_dmi_port_arbiter.sv
// tb_dmi_port_arbiter: directed and randomized checks against a transaction-level reference model.
module tb_dmi_port_arbiter;
`ifdef DMI_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  logic core_clk = 1'b0, core_rst_n = 1'b0;
  logic v [2], we [2];
  logic [6:0] a [2];
  logic [31:0] d [2];
  logic [1:0] ack;
  logic [31:0] rdata [2];
  logic reg_en, reg_wr_en, busy, gid;
  logic [6:0] reg_wr_addr;
  logic [31:0] reg_wr_data, rd_data;
  int checks = 0, errors = 0;
  int m_step, n0, n1;
  logic m_gid, m_last, m_we;
  logic [6:0] m_addr;
  logic [31:0] m_data;
  logic [31:0] m_rd [2];
  int order [$];

  dmi_port_arbiter dut (
    .core_clk(core_clk), .core_rst_n(core_rst_n),
    .req0_valid(v[0]), .req0_we(we[0]), .req0_addr(a[0]), .req0_wdata(d[0]),
    .req0_ack(ack[0]), .req0_rdata(rdata[0]),
    .req1_valid(v[1]), .req1_we(we[1]), .req1_addr(a[1]), .req1_wdata(d[1]),
    .req1_ack(ack[1]), .req1_rdata(rdata[1]),
    .reg_en(reg_en), .reg_wr_en(reg_wr_en), .reg_wr_addr(reg_wr_addr),
    .reg_wr_data(reg_wr_data), .rd_data(rd_data), .busy(busy), .grant_id(gid)
  );

  always #5 core_clk = ~core_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // A transaction occupies three cycles from grant: step 1 issue, step 2 response.
  task automatic model_step();
    if (!core_rst_n) begin
      m_step = 0; m_gid = 0; m_last = 1; m_we = 0; m_addr = 0; m_data = 0;
      m_rd[0] = 0; m_rd[1] = 0;
    end else if (m_step == 0) begin
      if (v[0] || v[1]) begin
        m_gid = !v[0] ? 1'b1 : (v[1] && RR && m_last == 1'b0);
        m_last = m_gid;
        m_we = we[m_gid]; m_addr = a[m_gid]; m_data = d[m_gid];
        m_step = 1;
      end
    end else if (m_step == 1) m_step = 2;
    else begin
      if (!m_we) m_rd[m_gid] = rd_data;
      m_step = 0;
    end
  endtask

  task automatic cyc();
    #1;
    check("busy", busy, m_step != 0);
    check("reg_en", reg_en, m_step == 1);
    check("reg_wr_en", reg_wr_en, m_step == 1 && m_we);
    check("addr", reg_wr_addr, m_addr);
    check("wdata", reg_wr_data, m_data);
    check("grant_id", gid, m_gid);
    check("ack0", ack[0], m_step == 2 && m_gid == 0);
    check("ack1", ack[1], m_step == 2 && m_gid == 1);
    check("rdata0", rdata[0], (m_step == 2 && m_gid == 0 && !m_we) ? rd_data : m_rd[0]);
    check("rdata1", rdata[1], (m_step == 2 && m_gid == 1 && !m_we) ? rd_data : m_rd[1]);
    model_step();
    @(negedge core_clk);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin v[i] = 0; we[i] = 0; a[i] = 0; d[i] = 0; end
    rd_data = 0;
    @(posedge core_clk);
    @(negedge core_clk);
    model_step();
    cyc();
    core_rst_n = 1;
    v[0] = 1; we[0] = 0; a[0] = 7'h11;
    cyc();
    #1 check("rd_en", reg_en, 1); check("rd_wr_en", reg_wr_en, 0); check("rd_addr", reg_wr_addr, 7'h11);
    a[0] = 7'h04;
    cyc();
    rd_data = 32'hDEADBEEF;
    #1 check("rd_ack", ack[0], 1); check("rd_data", rdata[0], 32'hDEADBEEF);
    v[0] = 0;
    cyc();
    check("rd_hold", rdata[0], 32'hDEADBEEF); check("mid_addr", reg_wr_addr, 7'h11);
    v[1] = 1; we[1] = 1; a[1] = 7'h10; d[1] = 32'h1;
    cyc();
    #1 check("wr_en", reg_en, 1); check("wr_wr_en", reg_wr_en, 1);
    check("wr_addr", reg_wr_addr, 7'h10); check("wr_data", reg_wr_data, 32'h1);
    cyc();
    #1 check("wr_ack", ack[1], 1); check("wr_rdata", rdata[1], 0);
    v[1] = 0;
    cyc();
    v[0] = 1; v[1] = 1; we[0] = 0; we[1] = 0; n0 = 0; n1 = 0;
    for (int c = 0; c < 40 && (v[0] || v[1]); c++) begin
      rd_data = $urandom;
      #1;
      if (ack[0]) begin order.push_back(0); n0++; if (n0 == 3) v[0] = 0; end
      if (ack[1]) begin order.push_back(1); n1++; if (n1 == 3) v[1] = 0; end
      cyc();
    end
    check("cont_n", order.size(), 6);
    for (int i = 0; i < order.size() && i < 6; i++)
      check("cont_order", order[i], RR ? (i % 2) : (i / 3));
    v[0] = 0; v[1] = 0;
    cyc();
    v[0] = 1; we[0] = 1; a[0] = 7'h22; d[0] = 32'h55;
    cyc();
    core_rst_n = 0;
    cyc();
    #1 check("rst_busy", busy, 0); check("rst_ack", ack, 0);
    check("rst_addr", reg_wr_addr, 0); check("rst_data", reg_wr_data, 0); check("rst_r0", rdata[0], 0);
    core_rst_n = 1;
    cyc();
    cyc();
    #1 check("post_rst_ack", ack[0], 1);
    v[0] = 0;
    cyc();
    repeat (3000) begin
      core_rst_n = ($urandom_range(63) != 0);
      rd_data = $urandom;
      for (int i = 0; i < 2; i++) begin
        if (ack[i]) v[i] = 0;
        if (!v[i] && $urandom_range(2) == 0) begin
          v[i] = 1; we[i] = $urandom; a[i] = $urandom; d[i] = $urandom;
        end else if (v[i] && m_step != 0 && m_gid == i) begin
          we[i] = $urandom; a[i] = $urandom; d[i] = $urandom;
        end
      end
      cyc();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dmi_port_arbiter.md
DMI_PORT_ARBITER -- requirements
Module: dmi_port_arbiter

Interface
REQ-001 Parameters SHALL be one per line as follows.
- ADDR_W, 7, DMI register address width.
- DATA_W, 32, DMI data width.

REQ-002 Ports SHALL be one per line as follows.
- core_clk  in  1  sole clock, all state on rising edge.
- core_rst_n  in  1  reset, synchronous, active-low.
- req0_valid  in  1  requester 0 (JTAG DMI path) request, level.
- req0_we  in  1  requester 0 write (1) / read (0).
- req0_addr  in  ADDR_W  requester 0 register address.
- req0_wdata  in  DATA_W  requester 0 write data.
- req0_ack  out  1  requester 0 completion pulse.
- req0_rdata  out  DATA_W  requester 0 read result.
- req1_valid, req1_we, req1_addr, req1_wdata, req1_ack, req1_rdata: same as requester 0, for requester 1 (SoC debug mailbox).
- reg_en  out  1  core DMI register access strobe.
- reg_wr_en  out  1  core DMI write enable.
- reg_wr_addr  out  ADDR_W  core DMI address.
- reg_wr_data  out  DATA_W  core DMI write data.
- rd_data  in  DATA_W  core DMI read data, valid the cycle after reg_en.
- busy  out  1  high in any state other than IDLE.
- grant_id  out  1  index of the current or most recent winner.

Function
REQ-003 The FSM SHALL have exactly three states: IDLE, ISSUE and RESP.
REQ-004 IDLE with any reqN_valid high: select a winner, latch its we/addr/wdata, set grant_id, move to ISSUE next cycle.
REQ-005 ISSUE:
- reg_en=1 for exactly one cycle.
- reg_wr_en = latched we.
- reg_wr_addr and reg_wr_data = latched values.
- Next state is RESP.
REQ-006 RESP:
- Capture rd_data into reqN_rdata of the winner, for reads only.
- For writes, reqN_rdata is unchanged.
- Assert reqN_ack of the winner for this one cycle only.
- Next state is IDLE.
REQ-007 Minimum transaction is 3 cycles (grant, issue, response); back-to-back requests SHALL NOT skip IDLE.
REQ-008 Requester contract: reqN_valid and its fields hold until ack; reqN_valid is low in the cycle after ack unless a new request is intended.
REQ-009 Changes on request inputs after the grant SHALL NOT affect the in-flight access.
REQ-010 Outside ISSUE: reg_en=0 and reg_wr_en=0; reg_wr_addr and reg_wr_data hold their last latched values.
REQ-011 The arbiter SHALL never assert both acks in the same cycle, nor an ack for a requester not granted.
REQ-012 The loser of a simultaneous request stays pending and SHALL be granted in the IDLE cycle following the winner's RESP.

Reset
REQ-013 With core_rst_n low at a clock edge, the following SHALL apply next cycle:
- State = IDLE.
- reg_en, reg_wr_en, req0_ack, req1_ack, busy = 0.
- reg_wr_addr, reg_wr_data, req0_rdata, req1_rdata = 0.
- grant_id = 0; round-robin pointer = "last granted 1".
REQ-014 Reset during ISSUE or RESP SHALL abort the access with no ack generated; reset SHALL NOT act asynchronously.

Configuration
REQ-015 Macro DMI_ARB_ROUND_ROBIN_EN selects the arbitration policy.
- Defined: on simultaneous requests, the requester not granted last wins; the pointer updates at each grant.
- Undefined: fixed priority, requester 0 always wins simultaneous requests; no pointer register is implemented.
- Single-requester behaviour SHALL be identical in both builds.

Verification
REQ-016 Directed scenarios the bench SHALL cover:
- Read: req0 read addr 0x11, rd_data=0xDEADBEEF in RESP -> reg_en 1 cycle, reg_wr_en=0, addr 0x11, req0_ack in cycle 3, req0_rdata=0xDEADBEEF.
- Write: req1 write addr 0x10 data 0x00000001 -> reg_en=reg_wr_en=1 for 1 cycle with that addr/data; req1_ack pulses; req1_rdata unchanged.
- Contention, RR build: both request 3 times continuously -> grant order 0,1,0,1,0,1; fixed build -> 0,0,0 then 1,1,1.
- Mid-flight change: req0 changes addr 0x11 -> 0x04 during ISSUE -> core sees 0x11.
- Reset in ISSUE: core_rst_n low one cycle -> no ack, all outputs 0 next cycle, next request completes normally.
